// File: rtl/neuron_pkg.sv
// Shared types and constants for the sequential fixed-point neuron.
// Includes the saturating 64->32 bit clamp used by the MAC step.
package neuron_pkg;

    localparam int          DATA_W        = 32;
    localparam int          FRAC_BITS_DEF = 16;
    localparam logic [2:0]  BIAS_ADDR     = 3'd4;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DONE
    } state_t;

    localparam logic signed [63:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [63:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

    function automatic data_t sat32(input logic signed [63:0] x);
        if (x > SAT_MAX)
            return data_t'(SAT_MAX[31:0]);
        else if (x < SAT_MIN)
            return data_t'(SAT_MIN[31:0]);
        else
            return data_t'(x[31:0]);
    endfunction

endpackage

// File: rtl/neuron_sat_mul_add.sv
// Combinational step: o_sum = sat32(i_acc + sat32((i_data * i_weight) >>> FRAC_BITS)).
module neuron_sat_mul_add
    import neuron_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  data_t i_acc,
    input  data_t i_data,
    input  data_t i_weight,
    output data_t o_sum
);

    logic signed [63:0] w_prod;
    logic signed [63:0] w_shift;
    data_t              w_term;
    logic signed [63:0] w_sum;

    // Full 64-bit product cannot overflow for two 32-bit signed operands.
    assign w_prod  = 64'(i_data) * 64'(i_weight);
    assign w_shift = w_prod >>> FRAC_BITS;
    assign w_term  = sat32(w_shift);
    assign w_sum   = 64'(i_acc) + 64'(w_term);
    assign o_sum   = sat32(w_sum);

endmodule

// File: rtl/neuron_mac_seq.sv
// Four-input neuron evaluated over four cycles through an external source selector.
// Define NEURON_RELU_EN for a ReLU activation; otherwise the activation is identity.
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int FRAC_BITS = FRAC_BITS_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [1:0]               sel,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     wr_en,
    input  logic [2:0]               wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] result
);

    state_t     r_state;
    state_t     w_next;
    data_t      r_acc;
    logic [1:0] r_idx;
    data_t      r_w [0:3];
    data_t      r_bias;
    data_t      w_sum;

    neuron_sat_mul_add #(
        .FRAC_BITS (FRAC_BITS)
    ) u_mac (
        .i_acc    (r_acc),
        .i_data   (data_in),
        .i_weight (r_w[r_idx]),
        .o_sum    (w_sum)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_acc <= r_bias;
                        r_idx <= '0;
                    end
                end
                ST_ACCUM: begin
                    r_acc <= w_sum;
                    r_idx <= r_idx + 2'd1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: the weight file is a handful of flops that must read back as zero after reset, so it is reset explicitly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w    <= '{default: '0};
            r_bias <= '0;
        end else if (wr_en) begin
            if (wr_addr == BIAS_ADDR)
                r_bias <= wr_data;
            else if (wr_addr < BIAS_ADDR)
                r_w[wr_addr[1:0]] <= wr_data;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next    = r_state;
        sel       = 2'd0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start)
                    w_next = ST_ACCUM;
            end
            ST_ACCUM: begin
                sel  = r_idx;
                busy = 1'b1;
                if (r_idx == 2'd3)
                    w_next = ST_DONE;
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

`ifdef NEURON_RELU_EN
    assign result = (r_acc < 0) ? '0 : r_acc;
`else
    assign result = r_acc;
`endif

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Scoreboard bench for neuron_mac_seq: expected results are queued at start and popped at the handshake.
module tb_neuron_mac_seq;

    logic               clk;
    logic               rst;
    logic               start;
    logic [1:0]         sel;
    logic signed [31:0] data_in;
    logic               wr_en;
    logic [2:0]         wr_addr;
    logic signed [31:0] wr_data;
    logic               busy;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] result;

    logic signed [31:0] src [4];
    logic signed [31:0] m_w [4];
    logic signed [31:0] m_bias;
    logic [31:0]        sb_q [$];
    logic [31:0]        got;

    int n_total = 0;
    int n_bad   = 0;

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    neuron_mac_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sel       (sel),
        .data_in   (data_in),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Upstream 4:1 selector model.
    assign data_in = src[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic longint clamp(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    function automatic logic [31:0] model();
        longint acc;
        longint p;
        acc = longint'(m_bias);
        for (int i = 0; i < 4; i++) begin
            p   = longint'(src[i]) * longint'(m_w[i]);
            p   = clamp(p >>> 16);
            acc = clamp(acc + p);
        end
`ifdef NEURON_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc[31:0];
    endfunction

    task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        if (a < 3'd4) m_w[a[1:0]] = d;
        else if (a == 3'd4) m_bias = d;
    endtask

    task automatic set_weights(input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3,
                               input logic [31:0] b);
        write_reg(3'd0, w0);
        write_reg(3'd1, w1);
        write_reg(3'd2, w2);
        write_reg(3'd3, w3);
        write_reg(3'd4, b);
    endtask

    // One evaluation: optional write to w1 at ACCUM step wr_n, hold cycles of backpressure,
    // and a start pulse coinciding with the handshake that must be ignored.
    task automatic run_eval(input int hold, input int wr_n, input logic [31:0] wr_d,
                            output logic [31:0] res);
        int n;
        start = 1'b1;
        sb_q.push_back(model());
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            check("sel_accum", 32'(sel), 32'(n));
            check("busy_accum", 32'(busy), 32'd1);
            if (n == wr_n) begin
                wr_en   = 1'b1;
                wr_addr = 3'd1;
                wr_data = wr_d;
            end
            @(negedge clk);
            wr_en = 1'b0;
            n++;
        end
        check("latency", 32'(n), 32'd4);
        if (wr_n >= 0) m_w[1] = wr_d;
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", result, sb_q[0]);
            check("hold_sel", 32'(sel), 32'd0);
            start = h[0];
            @(negedge clk);
        end
        start = 1'b0;
        check("done_valid", 32'(out_valid), 32'd1);
        check("done_sel", 32'(sel), 32'd0);
        res = result;
        check("result", res, sb_q.pop_front());
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin src[i] = '0; m_w[i] = '0; end
        m_bias = '0;
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Unit weights, sources 1..4 -> 10.0
        set_weights(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
        src = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
        run_eval(0, -1, '0, got);
        check("sum_const", got, 32'h000A_0000);

        // Positive saturation
        set_weights(32'h7FFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h7FFF_FFFF);
        src = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        run_eval(0, -1, '0, got);
        check("sat_pos_const", got, 32'h7FFF_FFFF);

        // Negative saturation
        write_reg(3'd4, 32'h8000_0000);
        src = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
        run_eval(0, -1, '0, got);
`ifdef NEURON_RELU_EN
        check("sat_neg_const", got, 32'h0);
`else
        check("sat_neg_const", got, 32'h8000_0000);
`endif

        // Negative inputs -> -4.0 or ReLU 0
        set_weights(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
        src = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
        run_eval(0, -1, '0, got);
`ifdef NEURON_RELU_EN
        check("neg_const", got, 32'h0);
`else
        check("neg_const", got, 32'hFFFC_0000);
`endif

        // Mixed fractional weights; writes to ignored addresses must not disturb state
        set_weights(32'h0000_8000, 32'hFFFF_0000, 32'h0003_0000, 32'h0, 32'h0000_1234);
        write_reg(3'd5, 32'hDEAD_BEEF);
        write_reg(3'd7, 32'h1111_1111);
        src = '{32'h0004_0000, 32'h0001_8000, 32'hFFFE_0000, 32'h7FFF_FFFF};
        run_eval(0, -1, '0, got);

        // Backpressure for 10 cycles with start pulses
        src = '{32'h0002_0000, 32'h0001_0000, 32'h0000_4000, 32'h0005_0000};
        run_eval(10, -1, '0, got);

        // Write to w1 in the cycle it is consumed: old value now, new value next time
        set_weights(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0);
        src = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
        run_eval(0, 1, 32'h0002_0000, got);
        check("wr_old_const", got, 32'h000A_0000);
        run_eval(0, -1, '0, got);
        check("wr_new_const", got, 32'h000C_0000);

        // Reset at T+2 discards the evaluation and clears weights
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) m_w[i] = '0;
        m_bias = '0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sel", 32'(sel), 32'd0);
        check("mid_rst_result", result, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_no_valid", 32'(out_valid), 32'd0);
        end
        run_eval(0, -1, '0, got);
        check("mid_rst_sum", got, 32'h0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/neuron_mac_seq.md
NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

Interface
REQ-001 Parameter FRAC_BITS, default 16: fractional bits of the signed fixed-point format (Q15.16 at default).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request one neuron evaluation; sampled only in IDLE.
REQ-005 sel  output  2  source select driven to the upstream 4:1 32-bit selector.
REQ-006 data_in  input  32  signed selected source value, combinationally valid in the same cycle as sel.
REQ-007 wr_en  input  1  weight/bias write strobe.
REQ-008 wr_addr  input  3  0-3 select weight w0-w3; 4 selects bias; 5-7 are ignored.
REQ-009 wr_data  input  32  signed write value.
REQ-010 busy  output  1  high in ACCUM and DONE.
REQ-011 out_valid  output  1  result available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 result  output  32  signed neuron output.

Function
REQ-014 FSM states: IDLE, ACCUM, DONE.
REQ-015 IDLE with start=1: acc<=bias, idx<=0, next state ACCUM; start is ignored in any other state.
REQ-016 ACCUM: sel=idx; acc<=sat32(acc + sat32((data_in*w[idx]) >>> FRAC_BITS)); idx<=idx+1.
REQ-017 ACCUM with idx==3: after this accumulate, next state DONE; idx wraps to 0.
REQ-018 Latency: start sampled at edge T; four accumulates at edges T+1..T+4; out_valid=1 from cycle T+5.
REQ-019 Product width: 64-bit signed product, arithmetic right shift, then saturation to 32 bits.
REQ-020 Saturation limits: clamp to 0x7FFFFFFF / 0x80000000.
REQ-021 DONE: out_valid=1 and result stable until the cycle out_valid && out_ready, then IDLE.
REQ-022 Backpressure: result is held indefinitely while out_ready=0.
REQ-023 sel equals 0 outside ACCUM.
REQ-024 Weight/bias writes are accepted in any state and update at the clock edge.
REQ-025 A write to w[idx] in the same cycle that w[idx] is consumed: the old value is used.
REQ-026 A start in the same cycle as the DONE handshake is ignored.

Reset
REQ-027 rst=1 at any edge: state IDLE, acc=0, idx=0, w0-w3=0, bias=0.
REQ-028 Outputs under reset: sel=0, busy=0, out_valid=0, result=0.
REQ-029 Reset in mid-ACCUM or DONE discards the evaluation; no out_valid is produced.

Configuration
REQ-030 Macro NEURON_RELU_EN defined: result = (acc<0) ? 0 : acc.
REQ-031 Macro NEURON_RELU_EN undefined: result = acc (identity activation).

Structure
REQ-032 Shared package neuron_pkg holds the following:
- DATA_W=32 and the default FRAC_BITS constant;
- the FSM state enum typedef;
- the signed 32-bit data typedef;
- the bias address constant 4.
REQ-033 One sub-module, neuron_sat_mul_add: combinational saturating fixed-point multiply-accumulate step used by ACCUM.

Verification
REQ-034 Weights all 0x00010000, bias 0, data_in per sel = 1.0, 2.0, 3.0, 4.0; start -> result 0x000A0000 with out_valid at T+5; sel sequence 0,1,2,3 at T+1..T+4.
REQ-035 w0=0x7FFFFFFF, others 0, data_in=0x7FFFFFFF, bias 0x7FFFFFFF -> result 0x7FFFFFFF (saturated).
REQ-036 Weights 0x00010000, data_in -1.0 per sel, bias 0 -> result 0 with NEURON_RELU_EN, 0xFFFC0000 without.
REQ-037 out_ready=0 for 10 cycles in DONE -> out_valid and result held; start pulses ignored; IDLE one cycle after out_ready=1.
REQ-038 rst at T+2 of an evaluation -> next cycle busy=0, out_valid=0, sel=0, weights read back as 0 (sum test gives bias-only result 0).
REQ-039 wr_en to w1 at T+2 (cycle w1 consumed) -> old w1 used for that evaluation; new w1 used for the next.
